// File: rtl/vector_sweeper.sv
// vector_sweeper: steps a stimulus vector through binary/Gray/walking-one patterns and checks a 1-bit response
module vector_sweeper #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             loop,
  input  logic [1:0]       mode,
  input  logic [1:0]       exp_sel,
  input  logic             pause,
  input  logic             resp_in,
  output logic [WIDTH-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [WIDTH-1:0] pat_idx,
  output logic [7:0]       err_count,
  output logic             err_flag,
  output logic [WIDTH-1:0] first_err_idx
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic [1:0] mode_q, exp_q;
  logic loop_q, sample, last, expv, mismatch;
  logic [WIDTH-1:0] last_idx;

  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [WIDTH-1:0] i);
    return m == 2'b01 ? i ^ (i >> 1) : m == 2'b10 ? WIDTH'(1) << i : i;
  endfunction

  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

  always_comb begin
    last_idx = mode_q == 2'b10 ? WIDTH'(WIDTH - 1) : '1;
    sample   = state == RUN && !pause && hold_cnt == HW'(HOLD - 1);
    last     = pat_idx == last_idx;
    expv     = exp_q == 2'b00 ? |vec_out : exp_q == 2'b01 ? ~|vec_out : exp_q == 2'b10 ? &vec_out : ^vec_out;
    mismatch = sample && resp_in != expv;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : (sample && last && !loop_q ? IDLE : RUN);
  end

  assign busy = state == RUN;

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_out       <= '0;
      pat_idx       <= '0;
      hold_cnt      <= '0;
      done          <= 1'b0;
      wrap          <= 1'b0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      mode_q        <= '0;
      exp_q         <= '0;
      loop_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          pat_idx       <= '0;
          hold_cnt      <= '0;
          vec_out       <= pattern(mode, '0);
          mode_q        <= mode;
          exp_q         <= exp_sel;
          loop_q        <= loop;
          err_count     <= '0;
          err_flag      <= 1'b0;
          first_err_idx <= '0;
        end
      end else if (!pause) begin
        if (mismatch) begin
          err_count <= err_count + 8'(err_count != 8'hff);
          if (!err_flag) begin
            err_flag      <= 1'b1;
            first_err_idx <= pat_idx;
          end
        end
        if (!sample) hold_cnt <= hold_cnt + 1'b1;
        else begin
          hold_cnt <= '0;
          if (!last) begin
            pat_idx <= pat_idx + 1'b1;
            vec_out <= pattern(mode_q, pat_idx + 1'b1);
          end else if (loop_q) begin
            pat_idx <= '0;
            vec_out <= pattern(mode_q, '0);
            wrap    <= 1'b1;
          end else begin
            pat_idx <= '0;
            vec_out <= '0;
            done    <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_sweeper.sv
// tb_vector_sweeper: table-driven sweeps plus hand-written pause/loop/reset/restart sequences
module tb_vector_sweeper;
  logic clk = 1'b0, rst, start, loop, pause, resp_in, tie0;
  logic [1:0] mode, exp_sel;
  logic [2:0] vec_out, pat_idx, first_err_idx;
  logic busy, done, wrap, err_flag;
  logic [7:0] err_count;
  int total = 0, passed = 0;

  vector_sweeper #(.WIDTH(3), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .mode(mode), .exp_sel(exp_sel),
    .pause(pause), .resp_in(resp_in), .vec_out(vec_out), .busy(busy), .done(done),
    .wrap(wrap), .pat_idx(pat_idx), .err_count(err_count), .err_flag(err_flag),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  always_comb resp_in = tie0 ? 1'b0 :
    exp_sel == 2'b00 ? |vec_out : exp_sel == 2'b01 ? ~|vec_out : exp_sel == 2'b10 ? &vec_out : ^vec_out;

  typedef struct {
    logic [1:0] m, e;
    logic t;
    int nb, ec, ef, fi;
  } vec_t;

  function automatic logic [2:0] pat(input logic [1:0] m, input int i);
    logic [2:0] b = 3'(i);
    return m == 2'b01 ? b ^ (b >> 1) : m == 2'b10 ? 3'(1 << i) : b;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic run(input logic [1:0] m, input logic [1:0] e, input logic t,
                     input int p_at, input int p_len, input int rs_at,
                     output int nb, output int bad);
    int c = 0;
    mode = m; exp_sel = e; tie0 = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nb = 0; bad = 0;
    while (busy && nb < 500) begin
      if (vec_out !== pat(m, c / 4) || pat_idx !== 3'(c / 4)) bad++;
      pause = nb >= p_at && nb < p_at + p_len;
      start = nb == rs_at;
      if (!pause) c++;
      nb++;
      @(negedge clk);
    end
    pause = 1'b0; start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    int nb, bad, wraps;
    tbl[0] = '{2'b00, 2'b00, 1'b0, 32, 0, 0, 0};
    tbl[1] = '{2'b01, 2'b00, 1'b0, 32, 0, 0, 0};
    tbl[2] = '{2'b10, 2'b00, 1'b0, 12, 0, 0, 0};
    tbl[3] = '{2'b00, 2'b00, 1'b1, 32, 7, 1, 1};
    tbl[4] = '{2'b00, 2'b01, 1'b1, 32, 1, 1, 0};
    tbl[5] = '{2'b11, 2'b10, 1'b0, 32, 0, 0, 0};
    tbl[6] = '{2'b01, 2'b11, 1'b1, 32, 4, 1, 1};
    tbl[7] = '{2'b10, 2'b11, 1'b1, 12, 3, 1, 0};
    rst = 1'b1; start = 1'b1; loop = 1'b0; pause = 1'b0; mode = 2'b00; exp_sel = 2'b00; tie0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_idx", pat_idx, 0);
    chk("rst_errc", err_count, 0);
    chk("rst_errf", err_flag, 0);
    chk("rst_first", first_err_idx, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].m, tbl[i].e, tbl[i].t, -1, 0, -1, nb, bad);
      chk($sformatf("v%0d_busy_cycles", i), nb, tbl[i].nb);
      chk($sformatf("v%0d_seq_bad", i), bad, 0);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_vec_idle", i), vec_out, 0);
      chk($sformatf("v%0d_errc", i), err_count, tbl[i].ec);
      chk($sformatf("v%0d_errf", i), err_flag, tbl[i].ef);
      chk($sformatf("v%0d_first", i), first_err_idx, tbl[i].fi);
      @(negedge clk);
      chk($sformatf("v%0d_done_once", i), done, 0);
    end
    run(2'b00, 2'b00, 1'b0, 9, 10, -1, nb, bad);
    chk("pause_busy_cycles", nb, 42);
    chk("pause_seq_bad", bad, 0);
    chk("pause_done", done, 1);
    chk("pause_errc", err_count, 0);
    @(negedge clk);
    run(2'b00, 2'b00, 1'b0, -1, 0, 5, nb, bad);
    chk("restart_busy_cycles", nb, 32);
    chk("restart_seq_bad", bad, 0);
    chk("restart_done", done, 1);
    @(negedge clk);
    loop = 1'b1; mode = 2'b00; exp_sel = 2'b00; tie0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bad = 0; wraps = 0;
    for (int k = 0; k < 32; k++) begin
      if (vec_out !== pat(0, k / 4) || busy !== 1'b1) bad++;
      wraps += int'(wrap);
      @(negedge clk);
    end
    chk("loop_seq_bad", bad, 0);
    chk("loop_early_wrap", wraps, 0);
    chk("loop_wrap", wrap, 1);
    chk("loop_wrap_vec", vec_out, 0);
    chk("loop_wrap_idx", pat_idx, 0);
    chk("loop_busy", busy, 1);
    chk("loop_no_done", done, 0);
    @(negedge clk);
    chk("loop_wrap_once", wrap, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; loop = 1'b0;
    chk("loop_rst_busy", busy, 0);
    chk("loop_rst_vec", vec_out, 0);
    tie0 = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("mid_idx", pat_idx, 5);
    chk("mid_errc", err_count, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_vec", vec_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_errc", err_count, 0);
    chk("mid_rst_errf", err_flag, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("mid_rst_done_after", done, 0);
    chk("mid_rst_busy_after", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vector_sweeper.md
Name: vector_sweeper

Overview:
- Synthesizable, parametrised successor to the hand-toggled exhaustive stimulus used on small combinational gates.
- Steps a WIDTH-bit input vector through a selectable pattern sequence (binary, Gray, walking-one) and holds each pattern for HOLD clock cycles.
- Samples a 1-bit DUT response at the end of each hold window and checks it against a selectable reference function.
- Sits between a board/bench controller and any small combinational DUT; reports done, wrap and error statistics.

Parameters:
- WIDTH, 3, DUT input vector width (2..8).
- HOLD, 4, cycles each pattern is held (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin sweep; sampled only in IDLE.
- loop  in  1  1 = restart at index 0 after last pattern; latched at start.
- mode  in  2  00 binary, 01 Gray, 10 walking-one, 11 treated as binary; latched at start.
- exp_sel  in  2  reference function: 00 OR, 01 NOR, 10 AND, 11 XOR of vec_out; latched at start.
- pause  in  1  freezes the hold counter and pattern while high.
- resp_in  in  1  DUT response to vec_out.
- vec_out  out  WIDTH  stimulus to DUT.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at sweep end (non-loop only).
- wrap  out  1  one-cycle pulse when loop restarts at index 0.
- pat_idx  out  WIDTH  current pattern index.
- err_count  out  8  mismatch count, saturates at 255.
- err_flag  out  1  sticky, set on first mismatch.
- first_err_idx  out  WIDTH  pat_idx of first mismatch.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. All outputs, state, hold counter and latched controls go to 0; state = IDLE.
- Pattern count N: 2^WIDTH for binary/Gray; WIDTH for walking-one.
- Pattern function of idx:
  - Binary: idx.
  - Gray: idx ^ (idx >> 1).
  - Walking-one: 1 << idx.
- vec_out is registered and equals pattern(pat_idx) at all times in RUN.
- States:
  - IDLE: vec_out = 0; start = 1 → RUN next cycle with pat_idx = 0, hold_cnt = 0, vec_out = pattern(0). Same edge latches mode/loop/exp_sel and clears err_count, err_flag, first_err_idx.
  - RUN: start ignored.
  - Each cycle with pause = 0, hold_cnt increments.
  - When hold_cnt == HOLD-1 and pause = 0 (the sample cycle):
    - Compare resp_in with exp_sel function of the current vec_out.
    - On mismatch: err_count += 1 (saturating); if err_flag = 0, set err_flag and capture pat_idx into first_err_idx.
    - Then hold_cnt ← 0 and advance.
  - Advance, pat_idx < N-1: pat_idx + 1.
  - Advance, pat_idx == N-1 and loop = 1: pat_idx ← 0; wrap pulses 1 cycle, coincident with vec_out = pattern(0).
  - Advance, pat_idx == N-1 and loop = 0: → IDLE; done pulses 1 cycle in the first IDLE cycle; busy = 0; vec_out = 0; pat_idx = 0. Error outputs hold until next start.
- Pause with pause = 1 in RUN: hold_cnt, pat_idx and vec_out frozen; no sample taken; a sample cycle with pause high is deferred to the first cycle pause is low.
- HOLD = 1: a new pattern every cycle; every RUN cycle with pause low is a sample cycle.
- Run length: a non-loop sweep with no pause occupies exactly N×HOLD RUN cycles.
- rst mid-sweep: returns to IDLE with all reset values on the next edge; no done pulse.
- start and rst asserted together: rst wins.
- Loop mode: to stop, assert rst.

Test Plan:
- WIDTH=3, HOLD=4, mode=00, exp_sel=00, resp_in = model OR of vec_out, start 1 cycle → vec_out 000,001,…,111 each held 4 cycles; busy high 32 cycles; done pulse the cycle after; err_count=0, err_flag=0.
- mode=01 → vec_out sequence 000,001,011,010,110,111,101,100; done after 32 RUN cycles.
- mode=10 → vec_out 001,010,100; busy 12 cycles; done; pat_idx never exceeds 2.
- mode=00, exp_sel=00, resp_in tied 0 → err_count=7, err_flag=1, first_err_idx=1. Repeat with exp_sel=01, resp_in tied 0 → err_count=1, first_err_idx=0.
- pause high 10 cycles while pat_idx=2 → vec_out stays 010; busy 42 cycles total. Separately, loop=1 → after 111, wrap pulses with vec_out=000 and busy stays high.
- rst during pat_idx=5 → next cycle vec_out=0, busy=0, err_count=0, no done. Then start; a second start while busy is ignored → sequence begins at 000 and runs a single sweep.
